// File: rtl/axis_int_div_if.sv
// Operand and result channels of the ALU divider port, grouped as one bundle.
// The divider is the slave on both operand channels and drives the result strobe.
interface axis_int_div_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tvalid;

  // Operand channels: a word transfers on a rising clk edge where tvalid and
  // tready are both high; the producer holds tvalid/tdata until then. The
  // result channel has no tready: tvalid is a one-cycle strobe to be sampled.
  modport slave (
    input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
    input  s_axis_divisor_tdata,  s_axis_divisor_tvalid,
    output s_axis_dividend_tready, s_axis_divisor_tready,
    output m_axis_dout_tdata, m_axis_dout_tvalid
  );

  modport master (
    output s_axis_dividend_tdata, s_axis_dividend_tvalid,
    output s_axis_divisor_tdata,  s_axis_divisor_tvalid,
    input  s_axis_dividend_tready, s_axis_divisor_tready,
    input  m_axis_dout_tdata, m_axis_dout_tvalid
  );
endinterface

// File: rtl/axis_int_div.sv
// Iterative radix-2 integer divider: collects two operands, runs one restoring
// step per cycle, and strobes {quotient, remainder} for one cycle.
module axis_int_div #(
  parameter bit SIGNED = 1'b1,
  parameter int WIDTH  = 32
) (
  input  logic         clk,
  input  logic         resetn,
  axis_int_div_if.slave bus,
  output logic [1:0]   dbg_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             dividend_held;
  logic             divisor_held;
  logic [WIDTH-1:0] dvd_r;      // dividend magnitude, becomes the quotient as it shifts
  logic [WIDTH-1:0] dvs_r;      // divisor magnitude
  logic [WIDTH-1:0] rem_r;
  logic             dvd_sign;
  logic             dvs_sign;
  logic             dvs_zero;

  logic             dividend_hs;
  logic             divisor_hs;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             step_ok;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign bus.s_axis_dividend_tready = resetn && (state == IDLE) && !dividend_held;
  assign bus.s_axis_divisor_tready  = resetn && (state == IDLE) && !divisor_held;
  assign dividend_hs = bus.s_axis_dividend_tvalid && bus.s_axis_dividend_tready;
  assign divisor_hs  = bus.s_axis_divisor_tvalid  && bus.s_axis_divisor_tready;
  assign dbg_state   = state;

  // The remainder is always below the divisor, so WIDTH bits hold it; only the
  // shifted trial value needs the extra bit to expose the borrow.
  always_comb begin
    rem_shift = {rem_r, dvd_r[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_r};
    step_ok   = ~trial[WIDTH];
    rem_next  = step_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {dvd_r[WIDTH-2:0], step_ok};
    quo_fix   = quo_next;
    if (dvs_zero)
      quo_fix = '1;
    else if (dvd_sign ^ dvs_sign)
      quo_fix = -quo_next;
    rem_fix = dvd_sign ? -rem_next : rem_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state                  <= IDLE;
      cnt                    <= '0;
      dividend_held          <= 1'b0;
      divisor_held           <= 1'b0;
      bus.m_axis_dout_tvalid <= 1'b0;
      bus.m_axis_dout_tdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dividend_hs) begin
            dividend_held <= 1'b1;
            dvd_sign      <= SIGNED && bus.s_axis_dividend_tdata[WIDTH-1];
            dvd_r         <= (SIGNED && bus.s_axis_dividend_tdata[WIDTH-1]) ?
                             -bus.s_axis_dividend_tdata : bus.s_axis_dividend_tdata;
          end
          if (divisor_hs) begin
            divisor_held <= 1'b1;
            dvs_sign     <= SIGNED && bus.s_axis_divisor_tdata[WIDTH-1];
            dvs_zero     <= (bus.s_axis_divisor_tdata == '0);
            dvs_r        <= (SIGNED && bus.s_axis_divisor_tdata[WIDTH-1]) ?
                            -bus.s_axis_divisor_tdata : bus.s_axis_divisor_tdata;
          end
          if ((dividend_held || dividend_hs) && (divisor_held || divisor_hs)) begin
            state <= CALC;
            cnt   <= '0;
            rem_r <= '0;
          end
        end
        CALC: begin
          rem_r <= rem_next;
          dvd_r <= quo_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bus.m_axis_dout_tdata  <= {quo_fix, rem_fix};
            bus.m_axis_dout_tvalid <= 1'b1;
            state                  <= DONE;
          end
        end
        DONE: begin
          bus.m_axis_dout_tvalid <= 1'b0;
          dividend_held          <= 1'b0;
          divisor_held           <= 1'b0;
          state                  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_int_div.sv
// Bench for axis_int_div: a signed and an unsigned instance see identical
// operand traffic and are checked every cycle against a timeline model.
module tb_axis_int_div;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic [W-1:0] a_data, b_data;
  logic         a_vld, b_vld;
  logic [1:0]   dbg_s, dbg_u;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  axis_int_div_if #(.WIDTH(W)) bus_s ();
  axis_int_div_if #(.WIDTH(W)) bus_u ();

  assign bus_s.s_axis_dividend_tdata  = a_data;
  assign bus_s.s_axis_dividend_tvalid = a_vld;
  assign bus_s.s_axis_divisor_tdata   = b_data;
  assign bus_s.s_axis_divisor_tvalid  = b_vld;
  assign bus_u.s_axis_dividend_tdata  = a_data;
  assign bus_u.s_axis_dividend_tvalid = a_vld;
  assign bus_u.s_axis_divisor_tdata   = b_data;
  assign bus_u.s_axis_divisor_tvalid  = b_vld;

  axis_int_div #(.SIGNED(1'b1), .WIDTH(W)) dut_s (
    .clk(clk), .resetn(resetn), .bus(bus_s.slave), .dbg_state(dbg_s)
  );
  axis_int_div #(.SIGNED(1'b0), .WIDTH(W)) dut_u (
    .clk(clk), .resetn(resetn), .bus(bus_u.slave), .dbg_state(dbg_u)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (!sgn) return {a / b, a % b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // m_phase: -1 while collecting operands, else edges elapsed since the second
  // operand was taken; the result strobe belongs to edge 32, idle again at 33.
  logic [63:0] exp_q_s[$];
  logic [63:0] exp_q_u[$];
  logic [63:0] m_last_s = '0;
  logic [63:0] m_last_u = '0;
  logic [W-1:0] m_a, m_b;
  bit m_held_a = 0, m_held_b = 0;
  int m_phase = -1;

  initial begin : compare
    bit rdy_a, rdy_b, exp_v;
    @(posedge clk);
    forever begin
      @(negedge clk);
      rdy_a = resetn && (m_phase < 0) && !m_held_a;
      rdy_b = resetn && (m_phase < 0) && !m_held_b;
      exp_v = (m_phase == 32);
      check("s dividend_tready", 64'(bus_s.s_axis_dividend_tready), 64'(rdy_a));
      check("s divisor_tready",  64'(bus_s.s_axis_divisor_tready),  64'(rdy_b));
      check("u dividend_tready", 64'(bus_u.s_axis_dividend_tready), 64'(rdy_a));
      check("u divisor_tready",  64'(bus_u.s_axis_divisor_tready),  64'(rdy_b));
      check("s dout_tvalid", 64'(bus_s.m_axis_dout_tvalid), 64'(exp_v));
      check("u dout_tvalid", 64'(bus_u.m_axis_dout_tvalid), 64'(exp_v));
      check("s dout_tdata", bus_s.m_axis_dout_tdata, m_last_s);
      check("u dout_tdata", bus_u.m_axis_dout_tdata, m_last_u);
      // advance the model across the coming edge
      if (!resetn) begin
        m_phase  = -1;
        m_held_a = 0;
        m_held_b = 0;
        m_last_s = '0;
        m_last_u = '0;
        exp_q_s.delete();
        exp_q_u.delete();
      end else if (m_phase < 0) begin
        if (a_vld && rdy_a) begin m_held_a = 1; m_a = a_data; end
        if (b_vld && rdy_b) begin m_held_b = 1; m_b = b_data; end
        if (m_held_a && m_held_b) begin
          m_phase = 0;
          exp_q_s.push_back(ref_div(m_a, m_b, 1'b1));
          exp_q_u.push_back(ref_div(m_a, m_b, 1'b0));
        end
      end else begin
        m_phase++;
        if (m_phase == 32) begin
          m_last_s = exp_q_s.pop_front();
          m_last_u = exp_q_u.pop_front();
        end
        if (m_phase == 33) begin
          m_phase  = -1;
          m_held_a = 0;
          m_held_b = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Dividend raised ga cycles and divisor gb cycles after the call; each is
  // held until its handshake edge. Returns just after the last handshake.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input int ga, input int gb);
    int cyc = 0;
    bit done_a = 0, done_b = 0, hs_a, hs_b;
    a_data = a;
    b_data = b;
    a_vld  = (ga == 0);
    b_vld  = (gb == 0);
    while (!(done_a && done_b)) begin
      if (cyc > 300) begin
        n_cmp++;
        n_bad++;
        $display("FAIL handshake timeout: operands %h / %h not accepted, got done %0d%0d, expected 11",
                 a, b, done_a, done_b);
        a_vld = 0;
        b_vld = 0;
        return;
      end
      @(negedge clk);
      hs_a = a_vld && bus_s.s_axis_dividend_tready;
      hs_b = b_vld && bus_s.s_axis_divisor_tready;
      @(posedge clk);
      #1;
      cyc++;
      if (hs_a) begin done_a = 1; a_vld = 0; end
      if (hs_b) begin done_b = 1; b_vld = 0; end
      if (!done_a && cyc == ga) a_vld = 1;
      if (!done_b && cyc == gb) b_vld = 1;
    end
  endtask

  function automatic logic [31:0] rand_operand(input int kind);
    case (kind)
      0: return $urandom_range(0, 40);
      1: return -$urandom_range(1, 40);
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin : main
    resetn = 1'b0;
    a_vld  = 1'b0;
    b_vld  = 1'b0;
    a_data = '0;
    b_data = '0;

    // hand-computed results that pin the reference model
    check("ref 7/2",          ref_div(32'd7, 32'd2, 1'b1),                   64'h00000003_00000001);
    check("ref -7/2",         ref_div(32'hFFFF_FFF9, 32'd2, 1'b1),           64'hFFFFFFFD_FFFFFFFF);
    check("ref 7/-2",         ref_div(32'd7, 32'hFFFF_FFFE, 1'b1),           64'hFFFFFFFD_00000001);
    check("ref 100/7",        ref_div(32'd100, 32'd7, 1'b1),                 64'h0000000E_00000002);
    check("ref div0",         ref_div(32'h1234_5678, 32'd0, 1'b1),           64'hFFFFFFFF_12345678);
    check("ref ovf",          ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1),   64'h80000000_00000000);
    check("ref u FFFFFFFF/2", ref_div(32'hFFFF_FFFF, 32'd2, 1'b0),           64'h7FFFFFFF_00000001);
    check("ref 9/3",          ref_div(32'd9, 32'd3, 1'b1),                   64'h00000003_00000000);

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    send(32'd7, 32'd2, 0, 0);
    send(32'hFFFF_FFF9, 32'd2, 0, 0);
    send(32'd7, 32'hFFFF_FFFE, 0, 0);
    repeat (40) @(posedge clk);
    #1;
    send(32'd100, 32'd7, 0, 5);
    send(32'h1234_5678, 32'd0, 0, 0);
    send(32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    send(32'hFFFF_FFFF, 32'd2, 0, 0);
    send(32'hFFFF_FFF9, 32'd0, 0, 0);

    // abort a division part way through, then divide again
    send(32'd50, 32'd3, 0, 0);
    repeat (10) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    send(32'd9, 32'd3, 0, 0);

    for (int i = 0; i < 25; i++) begin
      send(rand_operand($urandom_range(0, 7)), rand_operand($urandom_range(0, 7)),
           $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(posedge clk);
      #1;
    end

    repeat (40) @(posedge clk);
    #1;
    check("pending results", 64'(exp_q_s.size() + exp_q_u.size()), 64'd0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
